data_path: RTL and testbench
============================

# data_path

Datapath of the machine: the executing end of the control interface driven by `control_path`. Holds the accumulator register `Y` and the step register `S`. Updates both each clock according to the decoded control strobes. Returns the status flag `sIs6` that `control_path` uses to end the enumeration regime. All state is registered; `sIs6` is a Moore function of `S`.

## Interface
- `W`, default 8: width of `x` and `Y`.
- `SW`, default 4: width of `S`; must be ≥3 so the value 6 is representable.

Ports:
- `clk`  in  1  — single clock. All registers update on its rising edge.
- `rst`  in  1  — reset, synchronous and active-low. It is sampled on the rising edge of `clk`; `rst`=0 resets all registers.
- `x`  in  W  — external operand.
- `y_select_next`  in  2  — selects the next-value function for `Y`.
- `y_en`  in  1  — `Y` write enable.
- `y_store_x`  in  1  — loads `x` into `Y`.
- `s_step`  in  2  — step magnitude for `S`.
- `s_add`  in  1  — `S` direction: 1 = add, 0 = subtract.
- `s_en`  in  1  — `S` write enable.
- `s_zero`  in  1  — clears `S`.
- `y`  out  W  — current `Y`.
- `s`  out  SW  — current `S`.
- `sIs6`  out  1  — high when `S == 6`. Combinational from the `S` register only.
- `ovf`  out  1  — sticky arithmetic overflow flag for `Y`.
- `y_valid`  out  1  — 1-cycle pulse, registered; high for the cycle after any `Y` write.

## Operation
- **Reset** (`rst`=0 at an edge): `Y`=0, `S`=0, `ovf`=0, `y_valid`=0, so `sIs6`=0. Reset overrides every control input.
- **`S` register**, per edge, in priority order:
  1. `s_zero`=1 → `S` <= 0.
  2. else `s_en`=1 → `S` <= `S` ± zero-extended `s_step`. The sign is set by `s_add`. Arithmetic is modulo 2^SW: 1−2 → 15 at SW=4, and 14+2 → 0.
  3. else hold.
- **`Y` register**, per edge, in priority order:
  1. `y_store_x`=1 → `Y` <= `x`. This happens regardless of `y_en`. It also clears `ovf`.
  2. else `y_en`=1 → `Y` <= f(`y_select_next`):
     - 0: `Y` + zero-extended `S`
     - 1: `Y` − 1
     - 2: `Y` << 1, with the MSB shifted out
     - 3: `Y` + `x`
  3. else hold.
- **Width rule for `Y`:** all `Y` arithmetic is computed in W+1 bits, and bits [W-1:0] are stored.
- **Overflow:** `ovf` is set on any of the following, and once set stays 1 until `y_store_x` or reset:
  - carry-out of an add (selects 0 and 3);
  - borrow of select 1 (when `Y`=0);
  - MSB shifted out =1 on select 2.
- **`y_valid`** <= (`y_store_x` | `y_en`) on each non-reset edge.
- **`S` reads for the `Y` update:** the select-0 update uses the pre-edge value of `S`, even when `S` is updated in the same cycle.
- **Stale `s_zero`:** `control_path` may hold `s_zero` asserted (latched) while `active`=1. The datapath treats `s_zero` strictly as level-per-cycle; no edge detection.

## Timing
- Every register updates one clock after its controls are sampled; latency is 1 cycle from strobe to `y`, `s`, `ovf`, `y_valid`.
- `sIs6` follows `S` within the same cycle, with no input-to-output combinational path. This avoids a combinational loop through `control_path`, whose `next_active` and `next_regime` logic depends on `sIs6`.
- **Simultaneous events:**
  - `s_zero` with `s_en`: `s_zero` wins.
  - `y_store_x` with `y_en`: `y_store_x` wins.
  - Overflow in the same cycle as `y_store_x`: not possible, because `y_store_x` suppresses arithmetic; `ovf` ends at 0.
- **Reset mid-operation:** the next edge with `rst`=0 loads the reset values whatever the strobe states; no partial update.

## Structure
- **Shared package** holds:
  - `Y_SEL_ADD_S`=0, `Y_SEL_DEC`=1, `Y_SEL_SHL`=2, `Y_SEL_ADD_X`=3;
  - `S_TARGET`=6.
  - `control_path` and `data_path` import the same constants.
- **Sub-module:** `add_sub`, parameterized width, with inputs a, b, sub and outputs result and carry/borrow. It is instantiated once for `S` (width SW) and once for `Y` (width W). Estimated 150–250 lines RTL total.

## Test plan (W=8, SW=4)
- **Reset:** `rst`=0 for one edge with `s_en`=`y_en`=`y_store_x`=1 → `y`=0, `s`=0, `sIs6`=0, `ovf`=0, `y_valid`=0.
- **Count to 6:** `s_zero` one edge, then `s_en`=1, `s_add`=1, `s_step`=2 for 3 edges → `s` goes 2, 4, 6. `sIs6`=1 after the third edge; it drops after one more step (`s`=8).
- **`S` wrap:** `S`=1, `s_en`=1, `s_add`=0, `s_step`=2 → `s`=15 and `sIs6`=0. Then `s_zero`=`s_en`=1 → `s`=0.
- **Store priority:** `x`=8'h20, `y_store_x`=1, `y_en`=1, select 1 → `y`=8'h20 and `y_valid`=1. Next edge `y_en`=1 with select 1 → `y`=8'h1F.
- **Sticky overflow:** `Y`=8'hFE, `S`=3, `y_en`=1, select 0 → `y`=8'h01 and `ovf`=1. `ovf` stays 1 over 5 idle edges, then clears on `y_store_x` with `x`=8'h00.
- **Reset mid-operation:** `S`=5 and `Y`=8'h40 with `s_en`/`y_en` active; assert `rst`=0 → `s`=0 and `y`=0 on that edge. Operation resumes normally after `rst`=1.

Source files
------------

// File: rtl/data_path_pkg.sv
// Constants shared by control_path and data_path.
// The Y next-value select encoding and the S value that ends enumeration.
package data_path_pkg;

  typedef enum logic [1:0] {
    Y_SEL_ADD_S = 2'd0,
    Y_SEL_DEC   = 2'd1,
    Y_SEL_SHL   = 2'd2,
    Y_SEL_ADD_X = 2'd3
  } y_sel_e;

  localparam int S_TARGET = 6;

endpackage : data_path_pkg

// File: rtl/data_path_if.sv
// Control strobes from control_path and status/data returned by data_path.
// y_valid is a one-cycle strobe with no ready: the consumer must take y in that cycle.
interface data_path_if #(
  parameter int W  = 8,
  parameter int SW = 4
);

  logic [W-1:0]  x;
  logic [1:0]    y_select_next;
  logic          y_en;
  logic          y_store_x;
  logic [1:0]    s_step;
  logic          s_add;
  logic          s_en;
  logic          s_zero;

  logic [W-1:0]  y;
  logic [SW-1:0] s;
  logic          sIs6;
  logic          ovf;
  logic          y_valid;
  logic          s_wrap;

  modport master (
    output x, y_select_next, y_en, y_store_x, s_step, s_add, s_en, s_zero,
    input  y, s, sIs6, ovf, y_valid, s_wrap
  );

  modport slave (
    input  x, y_select_next, y_en, y_store_x, s_step, s_add, s_en, s_zero,
    output y, s, sIs6, ovf, y_valid, s_wrap
  );

endinterface : data_path_if

// File: rtl/data_path_add_sub.sv
// Width-parameterized adder/subtractor computed in WIDTH+1 bits.
// carry is the carry-out on add and the borrow on subtract.
module add_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] full;

  always_comb begin
    full = '0;
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
  end

  assign result = full[WIDTH-1:0];
  assign carry  = full[WIDTH];

endmodule : add_sub

// File: rtl/data_path.sv
// Datapath executing control_path strobes: accumulator Y, step register S,
// sticky overflow and the registered sIs6 status that ends enumeration.
module data_path
  import data_path_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input logic       clk,
  input logic       rst,
  data_path_if.slave dp
);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] s_q, s_d;
  logic          ovf_q, ovf_d;
  logic          y_valid_q, y_valid_d;
  logic          s_wrap_q, s_wrap_d;

  y_sel_e        y_sel;
  logic [W-1:0]  y_b;
  logic          y_sub;
  logic [W-1:0]  y_sum;
  logic          y_carry;
  logic [SW-1:0] s_b;
  logic [SW-1:0] s_sum;
  logic          s_carry;

  assign y_sel = y_sel_e'(dp.y_select_next);
  assign s_b   = SW'(dp.s_step);

  add_sub #(.WIDTH(SW)) u_s_add_sub (
    .a      (s_q),
    .b      (s_b),
    .sub    (~dp.s_add),
    .result (s_sum),
    .carry  (s_carry)
  );

  // Select 0 reads the pre-edge S, so S updates in the same cycle do not leak in.
  always_comb begin
    y_b   = '0;
    y_sub = 1'b0;
    case (y_sel)
      Y_SEL_ADD_S: y_b = W'(s_q);
      Y_SEL_DEC: begin
        y_b   = W'(1);
        y_sub = 1'b1;
      end
      Y_SEL_ADD_X: y_b = dp.x;
      default:     y_b = '0;
    endcase
  end

  add_sub #(.WIDTH(W)) u_y_add_sub (
    .a      (y_q),
    .b      (y_b),
    .sub    (y_sub),
    .result (y_sum),
    .carry  (y_carry)
  );

  always_comb begin
    y_d       = y_q;
    ovf_d     = ovf_q;
    y_valid_d = dp.y_store_x | dp.y_en;
    if (dp.y_store_x) begin
      y_d   = dp.x;
      ovf_d = 1'b0;
    end else if (dp.y_en) begin
      if (y_sel == Y_SEL_SHL) begin
        y_d   = {y_q[W-2:0], 1'b0};
        ovf_d = ovf_q | y_q[W-1];
      end else begin
        y_d   = y_sum;
        ovf_d = ovf_q | y_carry;
      end
    end
  end

  // s_zero is a plain level each cycle; a latched s_zero simply keeps S at 0.
  always_comb begin
    s_d      = s_q;
    s_wrap_d = 1'b0;
    if (dp.s_zero) begin
      s_d = '0;
    end else if (dp.s_en) begin
      s_d      = s_sum;
      s_wrap_d = s_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q       <= '0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
      y_valid_q <= 1'b0;
      s_wrap_q  <= 1'b0;
    end else begin
      y_q       <= y_d;
      s_q       <= s_d;
      ovf_q     <= ovf_d;
      y_valid_q <= y_valid_d;
      s_wrap_q  <= s_wrap_d;
    end
  end

  assign dp.y       = y_q;
  assign dp.s       = s_q;
  assign dp.sIs6    = (s_q == SW'(S_TARGET));
  assign dp.ovf     = ovf_q;
  assign dp.y_valid = y_valid_q;
  assign dp.s_wrap  = s_wrap_q;

endmodule : data_path

// File: tb/tb_data_path.sv
// Directed vector bench for data_path at W=8, SW=4.
module tb_data_path;

  logic clk;
  logic rst;

  data_path_if #(.W(8), .SW(4)) dp_if ();

  data_path #(.W(8), .SW(4)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] x;
    logic [1:0] sel;
    logic       y_en;
    logic       y_store_x;
    logic [1:0] step;
    logic       s_add;
    logic       s_en;
    logic       s_zero;
    logic [7:0] e_y;
    logic [3:0] e_s;
    logic       e_is6;
    logic       e_ovf;
    logic       e_yv;
    logic       e_wrap;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic r, input logic [7:0] x, input logic [1:0] sel, input logic yen,
    input logic st, input logic [1:0] step, input logic add, input logic sen,
    input logic zero, input logic [7:0] ey, input logic [3:0] es, input logic eis6,
    input logic eovf, input logic eyv, input logic ewrap);
    vec_t v;
    v.rst = r; v.x = x; v.sel = sel; v.y_en = yen; v.y_store_x = st;
    v.step = step; v.s_add = add; v.s_en = sen; v.s_zero = zero;
    v.e_y = ey; v.e_s = es; v.e_is6 = eis6; v.e_ovf = eovf; v.e_yv = eyv;
    v.e_wrap = ewrap;
    return v;
  endfunction

  task automatic check_val(input string name, input int idx,
                           input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst;
    dp_if.x              = v.x;
    dp_if.y_select_next  = v.sel;
    dp_if.y_en           = v.y_en;
    dp_if.y_store_x      = v.y_store_x;
    dp_if.s_step         = v.step;
    dp_if.s_add          = v.s_add;
    dp_if.s_en           = v.s_en;
    dp_if.s_zero         = v.s_zero;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_val("y",       idx, dp_if.y,              v.e_y);
    check_val("s",       idx, {4'h0, dp_if.s},      {4'h0, v.e_s});
    check_val("sIs6",    idx, {7'h0, dp_if.sIs6},   {7'h0, v.e_is6});
    check_val("ovf",     idx, {7'h0, dp_if.ovf},    {7'h0, v.e_ovf});
    check_val("y_valid", idx, {7'h0, dp_if.y_valid},{7'h0, v.e_yv});
    check_val("s_wrap",  idx, {7'h0, dp_if.s_wrap}, {7'h0, v.e_wrap});
  endtask

  initial begin
    drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //             rst x      sel yen st step add sen zro | y      s   is6 ovf yv wrap
    vecs.push_back(mk(0, 8'hAA, 3, 1, 1, 3, 1, 1, 0,  8'h00, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  8'h00, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1,  8'h00, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 0,  8'h00, 2,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 0,  8'h00, 4,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 0,  8'h00, 6,  1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 0,  8'h00, 8,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1,  8'h00, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 1, 0,  8'h00, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 0, 1, 0,  8'h00, 15, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 1,  8'h00, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 0, 1, 0,  8'h00, 14, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 2, 1, 1, 0,  8'h00, 0,  0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h20, 1, 1, 1, 0, 0, 0, 0,  8'h20, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 1, 1, 0, 0, 0, 0, 0,  8'h1F, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  8'h1F, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 2, 1, 0, 0, 0, 0, 0,  8'h3E, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h10, 3, 1, 0, 0, 0, 0, 0,  8'h4E, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 3, 1, 1, 0,  8'h4E, 3,  0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 3, 1, 1, 0,  8'h51, 6,  1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 1, 0, 0, 0, 0,  8'h00, 6,  1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 1, 1, 0, 0, 0, 0, 0,  8'hFF, 6,  1, 1, 1, 0));
    vecs.push_back(mk(1, 8'h80, 0, 0, 1, 0, 0, 0, 0,  8'h80, 6,  1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 2, 1, 0, 0, 0, 0, 0,  8'h00, 6,  1, 1, 1, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 0, 0, 0, 0,  8'hF0, 6,  1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h20, 3, 1, 0, 0, 0, 0, 0,  8'h10, 6,  1, 1, 1, 0));
    vecs.push_back(mk(1, 8'hFE, 0, 0, 1, 0, 0, 0, 0,  8'hFE, 6,  1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 3, 0, 1, 0,  8'hFE, 3,  0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 0, 0,  8'h01, 3,  0, 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Sticky overflow across idle cycles, then cleared by a store.
    for (int i = 0; i < 5; i++)
      apply(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h01, 3, 0, 1, 0, 0), 100 + i);
    apply(mk(1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00, 3, 0, 0, 1, 0), 105);

    // Reset in the middle of active strobes, then normal resumption.
    apply(mk(1, 8'h40, 0, 0, 1, 2, 1, 1, 0, 8'h40, 5, 0, 0, 1, 0), 200);
    apply(mk(0, 8'h01, 3, 1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0), 201);
    apply(mk(1, 8'h05, 3, 1, 0, 2, 1, 1, 0, 8'h05, 2, 0, 0, 1, 0), 202);
    apply(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h05, 2, 0, 0, 0, 0), 203);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_path
